// File: rtl/clock_pkg.sv
// clock_pkg: shared mode encoding, digit masks and a counter width
// helper for the wall-clock controller.
package clock_pkg;

   typedef enum logic [1:0] {
      MODE_RUN      = 2'd0,
      MODE_SET_HOUR = 2'd1,
      MODE_SET_MIN  = 2'd2
   } mode_t;

   localparam logic [7:0] HOUR_DIGITS_MASK = 8'b0011_0000;
   localparam logic [7:0] MIN_DIGITS_MASK  = 8'b0000_1100;

   function automatic int unsigned cnt_w(input int unsigned v);
      return (v <= 32'd1) ? 32'd1 : 32'($clog2(v));
   endfunction

endpackage

// File: rtl/blink_gen.sv
// blink_gen: half-period counter and on/off phase flag used to
// blank the digit group being edited.
module blink_gen
   import clock_pkg::*;
#(
   parameter int unsigned HALF_CYCLES = 25_000_000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic enable,
   input  logic restart,
   output logic phase_on
);

   localparam int unsigned CW = cnt_w(HALF_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(HALF_CYCLES - 1);

   logic [CW-1:0] r_cnt;
   logic          r_phase;

   // Free-run while enabled; a restart or idle forces count 0, phase on.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt   <= '0;
         r_phase <= 1'b1;
      end else if (!enable || restart) begin
         r_cnt   <= '0;
         r_phase <= 1'b1;
      end else if (r_cnt == LAST) begin
         r_cnt   <= '0;
         r_phase <= ~r_phase;
      end else begin
         r_cnt   <= r_cnt + 1'b1;
      end
   end

   assign phase_on = r_phase;

endmodule

// File: rtl/time_set_controller.sv
// time_set_controller: RUN -> SET_HOUR -> SET_MIN -> RUN sequencer
// driving counter gating, adjust pulses and display blanking.
module time_set_controller
   import clock_pkg::*;
#(
   parameter int unsigned BLINK_HALF_CYCLES = 25_000_000,
   parameter int unsigned TIMEOUT_CYCLES    = 1_000_000_000
) (
   input  logic       CLK100MHZ,
   input  logic       CPU_RESETN,
   input  logic       btn_mode_pos,
   input  logic       btn_up_pos,
   input  logic       btn_down_pos,
   output mode_t      mode,
   output logic       run_en,
   output logic       sec_clear,
   output logic       hour_inc,
   output logic       hour_dec,
   output logic       min_inc,
   output logic       min_dec,
   output logic [7:0] blank_mask
);

   localparam int unsigned TW = cnt_w(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   mode_t         r_mode;
   logic [TW-1:0] r_idle;
   logic          r_run_en;
   logic          r_sec_clear;
   logic          r_hour_inc;
   logic          r_hour_dec;
   logic          r_min_inc;
   logic          r_min_dec;
   logic [7:0]    r_blank;

   mode_t         w_mode_nxt;
   logic [TW-1:0] w_idle_nxt;
   logic          w_sec_clear_nxt;
   logic          w_hour_inc_nxt;
   logic          w_hour_dec_nxt;
   logic          w_min_inc_nxt;
   logic          w_min_dec_nxt;
   logic [7:0]    w_blank_nxt;
   logic          w_any;
   logic          w_step;
   logic          w_phase_on;
   logic          w_blink_en;

   assign w_any      = btn_mode_pos | btn_up_pos | btn_down_pos;
   assign w_step     = btn_up_pos ^ btn_down_pos;
   assign w_blink_en = (w_mode_nxt != MODE_RUN);

   blink_gen #(
      .HALF_CYCLES (BLINK_HALF_CYCLES)
   ) u_blink (
      .i_clk    (CLK100MHZ),
      .i_rst_n  (CPU_RESETN),
      .enable   (w_blink_en),
      .restart  (w_any),
      .phase_on (w_phase_on)
   );

   // Next state, inactivity count and next output values.
   always_comb begin
      w_mode_nxt      = r_mode;
      w_idle_nxt      = '0;
      w_sec_clear_nxt = 1'b0;
      w_hour_inc_nxt  = 1'b0;
      w_hour_dec_nxt  = 1'b0;
      w_min_inc_nxt   = 1'b0;
      w_min_dec_nxt   = 1'b0;
      w_blank_nxt     = '0;
      unique case (r_mode)
         MODE_RUN: begin
            if (btn_mode_pos) w_mode_nxt = MODE_SET_HOUR;
         end
         MODE_SET_HOUR: begin
            if (btn_mode_pos) begin
               w_mode_nxt = MODE_SET_MIN;
            end else if (w_step) begin
               w_hour_inc_nxt = btn_up_pos;
               w_hour_dec_nxt = btn_down_pos;
            end else if (!w_any) begin
               if (r_idle == TO_LAST) w_mode_nxt = MODE_RUN;
               else w_idle_nxt = r_idle + 1'b1;
            end
         end
         MODE_SET_MIN: begin
            if (btn_mode_pos) begin
               w_mode_nxt      = MODE_RUN;
               w_sec_clear_nxt = 1'b1;
            end else if (w_step) begin
               w_min_inc_nxt = btn_up_pos;
               w_min_dec_nxt = btn_down_pos;
            end else if (!w_any) begin
               if (r_idle == TO_LAST) w_mode_nxt = MODE_RUN;
               else w_idle_nxt = r_idle + 1'b1;
            end
         end
         default: w_mode_nxt = MODE_RUN;
      endcase
      // A press shows the digits at once; otherwise follow the phase.
      if (!w_any && !w_phase_on) begin
         if (w_mode_nxt == MODE_SET_HOUR) w_blank_nxt = HOUR_DIGITS_MASK;
         if (w_mode_nxt == MODE_SET_MIN)  w_blank_nxt = MIN_DIGITS_MASK;
      end
   end

   // State, inactivity counter and output registers.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_mode      <= MODE_RUN;
         r_idle      <= '0;
         r_run_en    <= 1'b1;
         r_sec_clear <= 1'b0;
         r_hour_inc  <= 1'b0;
         r_hour_dec  <= 1'b0;
         r_min_inc   <= 1'b0;
         r_min_dec   <= 1'b0;
         r_blank     <= '0;
      end else begin
         r_mode      <= w_mode_nxt;
         r_idle      <= w_idle_nxt;
         r_run_en    <= (w_mode_nxt == MODE_RUN);
         r_sec_clear <= w_sec_clear_nxt;
         r_hour_inc  <= w_hour_inc_nxt;
         r_hour_dec  <= w_hour_dec_nxt;
         r_min_inc   <= w_min_inc_nxt;
         r_min_dec   <= w_min_dec_nxt;
         r_blank     <= w_blank_nxt;
      end
   end

   assign mode       = r_mode;
   assign run_en     = r_run_en;
   assign sec_clear  = r_sec_clear;
   assign hour_inc   = r_hour_inc;
   assign hour_dec   = r_hour_dec;
   assign min_inc    = r_min_inc;
   assign min_dec    = r_min_dec;
   assign blank_mask = r_blank;

endmodule

// File: tb/tb_time_set_controller.sv
// tb_time_set_controller: table vectors, directed corner sequences
// and random stimulus against a behavioural model.
module tb_time_set_controller;

   localparam int BH = 4;
   localparam int TO = 20;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       b_mode, b_up, b_down;
   logic [1:0] mode_o;
   logic       run_en, sec_clear;
   logic       hour_inc, hour_dec, min_inc, min_dec;
   logic [7:0] blank_mask;

   time_set_controller #(
      .BLINK_HALF_CYCLES (BH),
      .TIMEOUT_CYCLES    (TO)
   ) dut (
      .CLK100MHZ    (clk),
      .CPU_RESETN   (rst_n),
      .btn_mode_pos (b_mode),
      .btn_up_pos   (b_up),
      .btn_down_pos (b_down),
      .mode         (mode_o),
      .run_en       (run_en),
      .sec_clear    (sec_clear),
      .hour_inc     (hour_inc),
      .hour_dec     (hour_dec),
      .min_inc      (min_inc),
      .min_dec      (min_dec),
      .blank_mask   (blank_mask)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       bm, bu, bd;
      logic [1:0] mo;
      logic [5:0] flags;
      logic [7:0] bl;
   } vec_t;

   vec_t tbl[$];

   int n_checks = 0;
   int n_fail   = 0;

   // model state: mode, idle cycles in SET, cycles since blink restart
   int         m_mode, m_idle, m_j;
   logic [15:0] m_exp;

   function automatic logic [15:0] act();
      return {mode_o, run_en, sec_clear, hour_inc, hour_dec,
              min_inc, min_dec, blank_mask};
   endfunction

   task automatic check(input string nm, input logic [15:0] a,
                        input logic [15:0] e);
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, a, e, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_idle = 0; m_j = 0;
      m_exp  = {2'd0, 6'b100000, 8'h00};
   endtask

   task automatic model(input logic bm, bu, bd);
      int nm;
      logic sc, hi, hd, mi, md;
      logic [7:0] bl;
      nm = m_mode; sc = 0; hi = 0; hd = 0; mi = 0; md = 0; bl = 0;
      if (m_mode == 0) begin
         if (bm) nm = 1;
         m_idle = 0; m_j = 0;
      end else if (bm | bu | bd) begin
         if (bm) begin
            nm = (m_mode == 1) ? 2 : 0;
            sc = (m_mode == 2);
         end else if (bu != bd) begin
            if (m_mode == 1) begin hi = bu; hd = bd; end
            else begin mi = bu; md = bd; end
         end
         m_idle = 0; m_j = 0;
      end else if (m_idle == TO - 1) begin
         nm = 0; m_idle = 0; m_j = 0;
      end else begin
         if ((m_j / BH) % 2 == 1)
            bl = (m_mode == 1) ? 8'h30 : 8'h0C;
         m_idle++; m_j++;
      end
      m_mode = nm;
      m_exp = {nm[1:0], (nm == 0), sc, hi, hd, mi, md, bl};
   endtask

   task automatic step(input logic bm, bu, bd);
      b_mode = bm; b_up = bu; b_down = bd;
      model(bm, bu, bd);
      @(posedge clk); #1;
      b_mode = 0; b_up = 0; b_down = 0;
   endtask

   task automatic stepc(input logic bm, bu, bd, input string nm);
      step(bm, bu, bd);
      check(nm, act(), m_exp);
   endtask

   task automatic idle(input int n, input string nm);
      for (int k = 0; k < n; k++) stepc(0, 0, 0, nm);
   endtask

   initial begin
      b_mode = 0; b_up = 0; b_down = 0;
      rst_n = 1'b1;
      model_reset();
      #2 rst_n = 1'b0;
      #1 check("reset_state", act(), {2'd0, 6'b100000, 8'h00});
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("reset_release", act(), m_exp);

      // 1: idle in RUN
      idle(10, "run_idle");

      // 2,3,5: table of hand-derived vectors
      tbl.push_back({3'b000, 2'd0, 6'b100000, 8'h00});
      tbl.push_back({3'b100, 2'd1, 6'b000000, 8'h00});
      tbl.push_back({3'b010, 2'd1, 6'b001000, 8'h00});
      tbl.push_back({3'b010, 2'd1, 6'b001000, 8'h00});
      tbl.push_back({3'b001, 2'd1, 6'b000100, 8'h00});
      for (int k = 0; k < 4; k++)
         tbl.push_back({3'b000, 2'd1, 6'b000000, 8'h00});
      for (int k = 0; k < 4; k++)
         tbl.push_back({3'b000, 2'd1, 6'b000000, 8'h30});
      tbl.push_back({3'b000, 2'd1, 6'b000000, 8'h00});
      tbl.push_back({3'b100, 2'd2, 6'b000000, 8'h00});
      tbl.push_back({3'b010, 2'd2, 6'b000010, 8'h00});
      tbl.push_back({3'b001, 2'd2, 6'b000001, 8'h00});
      tbl.push_back({3'b011, 2'd2, 6'b000000, 8'h00});
      tbl.push_back({3'b110, 2'd0, 6'b110000, 8'h00});
      tbl.push_back({3'b000, 2'd0, 6'b100000, 8'h00});
      tbl.push_back({3'b010, 2'd0, 6'b100000, 8'h00});
      foreach (tbl[i]) begin
         step(tbl[i].bm, tbl[i].bu, tbl[i].bd);
         check($sformatf("vec%0d", i), act(),
               {tbl[i].mo, tbl[i].flags, tbl[i].bl});
      end

      // 4: timeout after 20 idle cycles, no sec_clear
      stepc(1, 0, 0, "to_enter");
      idle(19, "to_wait");
      check("to_still_set", {14'd0, mode_o}, 16'd1);
      stepc(0, 0, 0, "to_fire");
      check("to_run", act(), {2'd0, 6'b100000, 8'h00});

      // 4b: press on cycle 19, then press on terminal count
      stepc(1, 0, 0, "to2_enter");
      idle(18, "to2_wait");
      stepc(0, 1, 0, "to2_up19");
      check("to2_inc19", act(), {2'd1, 6'b001000, 8'h00});
      idle(19, "to2_wait2");
      stepc(0, 1, 0, "to2_up_term");
      check("to2_inc_term", act(), {2'd1, 6'b001000, 8'h00});
      idle(20, "to2_timeout");
      check("to2_run", {14'd0, mode_o}, 16'd0);

      // 5: up+down counts as activity
      stepc(1, 0, 0, "ud_h");
      stepc(1, 0, 0, "ud_m");
      idle(15, "ud_wait");
      stepc(0, 1, 1, "ud_both");
      idle(19, "ud_wait2");
      check("ud_still_set", {14'd0, mode_o}, 16'd2);
      stepc(0, 0, 0, "ud_timeout");
      check("ud_run", {14'd0, mode_o}, 16'd0);

      // 6: asynchronous reset mid SET_MIN
      stepc(1, 0, 0, "ar_h");
      stepc(1, 0, 0, "ar_m");
      idle(6, "ar_wait");
      check("ar_blanked", {8'd0, blank_mask}, 16'h000C);
      #3 rst_n = 1'b0;
      #1 check("ar_async", act(), {2'd0, 6'b100000, 8'h00});
      model_reset();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("ar_release", act(), m_exp);

      // random stimulus with quiet windows to reach timeouts
      for (int i = 0; i < 900; i++) begin
         logic bm, bu, bd;
         bm = 0; bu = 0; bd = 0;
         if ((i % 90) < 60) begin
            bm = ($urandom_range(0, 11) == 0);
            bu = ($urandom_range(0, 5) == 0);
            bd = ($urandom_range(0, 5) == 0);
         end
         stepc(bm, bu, bd, "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
